// File: rtl/combo_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// combo_sweep_ctrl
//
// Clocked, repeatable self-check sweep for the 4-input / 16-bit combinational
// datapath. A sweep drives all 16 select vectors {A,B,C,D} with operand num_a
// (phase 0), then all 16 again with operand num_b (phase 1). On the last edge of
// each vector's hold, the block compares the datapath's continuous and
// procedural results. It counts mismatching vectors and records the first one.
//
// Parameters
//   SETTLE  cycles each vector is held (1..15); the compare is sampled on the
//           last edge of the hold
//   NUM_W   width of the numeric operand and results
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             begin a sweep (accepted only in IDLE)
//   abort             end an active sweep without producing done
//   num_a, num_b      phase-0 / phase-1 operands, captured on an accepted start
//   vec, num_in       registered stimulus to the datapath
//   cont_in, lreg_in  datapath bit results (continuous / procedural)
//   num_out, lnum_out datapath numeric results (continuous / procedural)
//   busy              sweep active
//   done              one-cycle completion pulse
//   pass              no mismatches at the most recent done
//   err_count         mismatching vectors in this sweep (0..32)
//   first_err_valid   a mismatch has been recorded in this sweep
//   first_err_idx     {phase, vec} of the first mismatch
// -----------------------------------------------------------------------------
module combo_sweep_ctrl #(
    parameter int SETTLE = 2,
    parameter int NUM_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [NUM_W-1:0] num_a,
    input  logic [NUM_W-1:0] num_b,
    output logic [3:0]       vec,
    output logic [NUM_W-1:0] num_in,
    input  logic             cont_in,
    input  logic             lreg_in,
    input  logic [NUM_W-1:0] num_out,
    input  logic [NUM_W-1:0] lnum_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [5:0]       err_count,
    output logic             first_err_valid,
    output logic [4:0]       first_err_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Hold counter runs 0..SETTLE-1; the terminal count marks the sample edge.
    localparam logic [3:0] HOLD_LAST = 4'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic [NUM_W-1:0] num_in_q, num_in_d;
    logic [NUM_W-1:0] cap_b_q, cap_b_d;
    logic             phase_q, phase_d;
    logic [3:0]       hold_q, hold_d;
    logic [5:0]       err_q, err_d;
    logic             fev_q, fev_d;
    logic [4:0]       fei_q, fei_d;
    logic             pass_q, pass_d;

    logic mismatch;

    assign mismatch = (cont_in != lreg_in) | (num_out != lnum_out);

    // NOTE: every variable gets its hold value before the case statement, so no
    // path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        num_in_d = num_in_q;
        cap_b_d = cap_b_q;
        phase_d = phase_q;
        hold_d  = hold_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fei_d   = fei_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    cap_b_d  = num_b;
                    vec_d    = 4'd0;
                    num_in_d = num_a;
                    phase_d  = 1'b0;
                    hold_d   = 4'd0;
                    err_d    = 6'd0;
                    fev_d    = 1'b0;
                    fei_d    = 5'd0;
                    pass_d   = 1'b0;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    // Abort wins over a sample on the same edge: the partial
                    // results stay exactly as they were before this edge.
                    state_d = ST_IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    hold_d = 4'd0;
                    if (mismatch) begin
                        err_d = err_q + 6'd1;
                        if (!fev_q) begin
                            fev_d = 1'b1;
                            fei_d = {phase_q, vec_q};
                        end
                    end
                    if (vec_q != 4'd15) begin
                        vec_d = vec_q + 4'd1;
                    end else if (!phase_q) begin
                        vec_d    = 4'd0;
                        phase_d  = 1'b1;
                        num_in_d = cap_b_q;
                    end else begin
                        state_d = ST_DONE;
                        // Loaded on entry so pass is valid during the done pulse.
                        pass_d  = (err_d == 6'd0);
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state is assigned with <= so every register
            // samples its pre-edge inputs regardless of statement order.
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q    <= 4'd0;
            num_in_q <= '0;
            cap_b_q  <= '0;
            phase_q  <= 1'b0;
            hold_q   <= 4'd0;
            err_q    <= 6'd0;
            fev_q    <= 1'b0;
            fei_q    <= 5'd0;
            pass_q   <= 1'b0;
        end else begin
            vec_q    <= vec_d;
            num_in_q <= num_in_d;
            cap_b_q  <= cap_b_d;
            phase_q  <= phase_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
            fev_q    <= fev_d;
            fei_q    <= fei_d;
            pass_q   <= pass_d;
        end
    end

    assign vec             = vec_q;
    assign num_in          = num_in_q;
    assign busy            = (state_q == ST_RUN);
    assign done            = (state_q == ST_DONE);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fei_q;

endmodule

// File: doc/combo_sweep_ctrl.md
# combo_sweep_ctrl

Self-checking sequencer for the 4-input / 16-bit combinational datapath. On `start` it drives all 16 values of the 4-bit select vector `{A,B,C,D}`, first with operand `num_a` and then with operand `num_b`, giving 32 vectors. For each vector it compares the datapath's two parallel implementations (continuous vs. procedural) and reports the mismatch count and the index of the first mismatch. It sits between the datapath instance and a host or bench, replacing a hand-written stimulus loop with a clocked, repeatable sweep.

## Interface
Parameters:
- `SETTLE`, default 2: cycles each vector is held; the compare is sampled on the last edge of the hold. Legal range is 1..15.
- `NUM_W`, default 16: width of the numeric datapath operand and results.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep; accepted only in IDLE.
- `abort`  in  1  terminate an active sweep; no `done` is produced.
- `num_a`  in  NUM_W  phase-0 operand, captured when `start` is accepted.
- `num_b`  in  NUM_W  phase-1 operand, captured when `start` is accepted.
- `vec`  out  4  drives `{A,B,C,D}` of the datapath; registered.
- `num_in`  out  NUM_W  drives the datapath `numIn`; registered.
- `cont_in`  in  1  datapath continuous-assign bit result.
- `lreg_in`  in  1  datapath procedural bit result.
- `num_out`  in  NUM_W  datapath continuous numeric result.
- `lnum_out`  in  NUM_W  datapath procedural numeric result.
- `busy`  out  1  high while a sweep is active.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass`  out  1  `err_count == 0` at the most recent `done`; held until the next accepted start.
- `err_count`  out  6  number of mismatching vectors, range 0..32.
- `first_err_valid`  out  1  at least one mismatch has occurred in this sweep.
- `first_err_idx`  out  5  `{phase, vec}` of the first mismatch.

## Operation
- States are IDLE, RUN and DONE.
- IDLE: `start=1` moves to RUN. On that edge the block:
  - captures `num_a` and `num_b`;
  - loads `vec=0` and `num_in=num_a`;
  - clears `phase`, the hold counter, `err_count`, `first_err_*` and `pass`;
  - sets `busy`.
- RUN, hold behaviour:
  - Each vector is held for `SETTLE` cycles.
  - On the last edge of the hold, the mismatch term is sampled: `(cont_in != lreg_in) | (num_out != lnum_out)`.
  - If the mismatch term is 1, `err_count` increments. If `first_err_valid` is 0, the block also loads `first_err_idx = {phase, vec}` and sets `first_err_valid`.
- RUN, advancing on that same edge:
  - If `vec < 15`: `vec` increments.
  - If `vec == 15` and `phase == 0`: `vec` wraps to 0, `phase` becomes 1, and `num_in` loads the captured `num_b`.
  - If `vec == 15` and `phase == 1`: go to DONE.
- DONE: lasts exactly one cycle, with `done=1`, `busy=0`, and `pass` loaded. Then go to IDLE.
- `abort=1` in RUN: return to IDLE on the next edge with `busy=0` and no `done`. `err_count`, `first_err_*` and `pass` keep their partial values; `pass` is not updated. Abort has priority over a compare sample on the same edge, so that sample is discarded.
- `start` in RUN or DONE is ignored. Changes to `num_a`/`num_b` after capture have no effect.
- `vec` and `num_in` keep their last values in IDLE.
- `err_count` is 6 bits and cannot overflow, since the maximum is 32.
- Reset (asynchronous, at any time including mid-sweep) forces:
  - state IDLE;
  - `vec=0`, `num_in=0`;
  - `busy=0`, `done=0`, `pass=0`;
  - `err_count=0`;
  - `first_err_valid=0`, `first_err_idx=0`.

## Timing
- Let E0 be the edge that accepts `start`.
- Vector k (0..31) is presented from edge E0 + k·SETTLE.
- Vector k is sampled at edge E0 + (k+1)·SETTLE.
- After the last sample, at edge E0 + 32·SETTLE, the FSM enters DONE. `done` is high for the cycle between E0 + 32·SETTLE and E0 + 32·SETTLE + 1.
- `busy` is high from E0 until the edge E0 + 32·SETTLE.
- A new `start` is accepted no earlier than edge E0 + 32·SETTLE + 1.
- With SETTLE=2 a sweep takes 64 cycles plus 1 DONE cycle.
- The datapath is purely combinational, so SETTLE=1 is functionally correct. Larger values give waveform visibility.

## Test plan
- Matching model (`lreg_in=cont_in`, `lnum_out=num_out`), `num_a=16'h125A`, `num_b=16'h34A5`, SETTLE=2:
  - `vec` steps 0..15 twice; `num_in` changes to 34A5 after vector 15.
  - `done` occurs at E0+64.
  - `err_count=0`, `pass=1`, `first_err_valid=0`.
- Inject a bit mismatch only when `phase=1` and `vec=5`: `err_count=1`, `first_err_idx=5'h15`, `pass=0`.
- Force `num_out != lnum_out` on every vector: `err_count=32`, `first_err_idx=0`, `pass=0`.
- Pulse `start` at E0+10 during a sweep: it is ignored and `done` still occurs exactly once at E0+64. Change `num_b` at E0+5: `num_in` still shows the captured value in phase 1.
- Inject mismatches at vectors 2 and 3, assert `abort` on the vector-3 sample edge:
  - `busy` drops and no `done` is produced;
  - `err_count=1` (the vector-3 sample is discarded), `first_err_idx=2`.
  - A following `start` runs a full clean sweep with `pass=1`.
- Assert `rst_n=0` asynchronously mid-sweep, between clock edges: all outputs are immediately at their reset values, and the block is idle after release.
